ddr_req_arbiter: RTL

//  Shares the single MIG DDR2 user command port between two requesters: the

---
 rtl/ddr_mgr_pkg.sv | 14 +
 rtl/ddr_burst_seq.sv | 70 +++++++
 rtl/ddr_req_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ddr_mgr_pkg.sv
// Shared types and default widths for the DDR manager request arbiter.
package ddr_mgr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int DEF_ADDR_W = 24;
  localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/ddr_burst_seq.sv
// Per-transaction burst sequencer: walks the burst address, counts issued and
// completed bursts, and flags the last accepted command and the final completion.
module ddr_burst_seq
  import ddr_mgr_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int BURST_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              cmd_ready,
  input  logic              burst_done,
  output logic              cmd_valid,
  output logic              cmd_rnw,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              last_accept,
  output logic              finished
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] completed;
  logic             busy;

  assign last_accept = cmd_valid && cmd_ready && (issued == len_q - LEN_W'(1));
  assign finished    = busy && burst_done && (completed == len_q - LEN_W'(1));

  // Handshake: a command is issued on a cycle where cmd_valid and cmd_ready are
  // both high; cmd_valid, cmd_addr and cmd_rnw hold until that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      issued    <= '0;
      completed <= '0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_rnw   <= 1'b0;
      cmd_addr  <= '0;
    end else if (start) begin
      len_q     <= start_len;
      issued    <= '0;
      completed <= '0;
      busy      <= (start_len != '0);
      cmd_valid <= (start_len != '0);
      cmd_rnw   <= rnw;
      cmd_addr  <= start_addr;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cmd_addr <= cmd_addr + ADDR_W'(BURST_INC);
        issued   <= issued + LEN_W'(1);
        if (last_accept) begin
          cmd_valid <= 1'b0;
        end
      end
      // Completions are counted whether they land while issuing or draining.
      if (busy && burst_done) begin
        completed <= completed + LEN_W'(1);
        if (finished) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Arbitrates the single MIG command port between the preload writer and the
// line-fetch reader; reads win unless a write has waited MAX_RD_RUN read grants.
module ddr_req_arbiter
  import ddr_mgr_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int BURST_INC  = 4,
  parameter int MAX_RD_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_grant,
  output logic              wr_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_grant,
  output logic              rd_done,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_rnw,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_burst_done,
  output logic              mem_sel,
  output logic [1:0]        fsm_state
);

  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  arb_state_t       state;
  logic [RUN_W-1:0] rd_run;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] len_q;
  logic             rnw_q;
  logic             start_q;
  logic             rd_wins;
  logic             last_accept;
  logic             seq_finished;
  logic             finish_now;

  assign rd_wins    = rd_req && !(wr_req && (rd_run == RUN_W'(MAX_RD_RUN)));
  assign finish_now = ((state == ST_ISSUE) && ((len_q == '0) || seq_finished)) ||
                      ((state == ST_DRAIN) && seq_finished);
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rd_run   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      rnw_q    <= 1'b0;
      start_q  <= 1'b0;
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      mem_sel  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      if (finish_now) begin
        state    <= ST_DONE;
        rd_done  <= rd_grant;
        wr_done  <= wr_grant;
        rd_grant <= 1'b0;
        wr_grant <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (init_done && (rd_req || wr_req)) begin
              state   <= ST_ISSUE;
              start_q <= 1'b1;
              if (rd_wins) begin
                rd_grant <= 1'b1;
                mem_sel  <= 1'b1;
                rnw_q    <= 1'b1;
                addr_q   <= rd_addr;
                len_q    <= rd_len;
                // The run only counts reads that made a pending write wait.
                if (!wr_req) begin
                  rd_run <= '0;
                end else if (rd_run != RUN_W'(MAX_RD_RUN)) begin
                  rd_run <= rd_run + RUN_W'(1);
                end
              end else begin
                wr_grant <= 1'b1;
                mem_sel  <= 1'b0;
                rnw_q    <= 1'b0;
                addr_q   <= wr_addr;
                len_q    <= wr_len;
                rd_run   <= '0;
              end
            end
          end
          ST_ISSUE: begin
            if (last_accept) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            state <= ST_DRAIN;
          end
          ST_DONE: begin
            state   <= ST_IDLE;
            mem_sel <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  ddr_burst_seq #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .BURST_INC (BURST_INC)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .start       (start_q),
    .rnw         (rnw_q),
    .start_addr  (addr_q),
    .start_len   (len_q),
    .cmd_ready   (mem_cmd_ready),
    .burst_done  (mem_burst_done),
    .cmd_valid   (mem_cmd_valid),
    .cmd_rnw     (mem_cmd_rnw),
    .cmd_addr    (mem_cmd_addr),
    .last_accept (last_accept),
    .finished    (seq_finished)
  );

endmodule
